// File: rtl/mux_scan_sequencer_if.sv
// Control, select and sample signals between the scan sequencer and its environment.
// No latency: plain wires grouped for port connection.
// No backpressure: all signals are level or single-cycle pulses.
interface mux_scan_sequencer_if;
  logic       start;
  logic       cont;
  logic       abort;
  logic       m;
  logic       s0;
  logic       s1;
  logic       busy;
  logic [2:0] sample;
  logic       sample_valid;

  // Environment side: drives control and the mux output, observes selects and results.
  modport master (
    output start, cont, abort, m,
    input  s0, s1, busy, sample, sample_valid
  );

  // Sequencer side.
  modport slave (
    input  start, cont, abort, m,
    output s0, s1, busy, sample, sample_valid
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps the two-level mux through sources u, v, w, sampling m after each dwell and publishing a 3-bit word.
// Latency: 3*DWELL cycles from start sampled to sample_valid; back-to-back scans in continuous mode.
// No backpressure: sample_valid is a one-cycle pulse; abort drops the scan in progress without publishing.
module mux_scan_sequencer #(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_scan_sequencer_if.slave bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEL_U,
    SEL_V,
    SEL_W
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // Only u and v need staging; w is taken straight from m on the publish edge.
  logic [1:0]       stage;
  logic             dwell_done;

  assign dwell_done = (cnt == CNT_LAST);

  // Scan FSM with registered selects, busy and result; selects switch on the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      stage            <= '0;
      bus.s0           <= 1'b0;
      bus.s1           <= 1'b0;
      bus.busy         <= 1'b0;
      bus.sample       <= 3'b000;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      if (bus.abort) begin
        state    <= IDLE;
        cnt      <= '0;
        stage    <= '0;
        bus.s0   <= 1'b0;
        bus.s1   <= 1'b0;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state    <= SEL_U;
              cnt      <= '0;
              bus.busy <= 1'b1;
              bus.s0   <= 1'b0;
              bus.s1   <= 1'b0;
            end
          end
          SEL_U: begin
            if (dwell_done) begin
              stage[0] <= bus.m;
              cnt      <= '0;
              state    <= SEL_V;
              bus.s0   <= 1'b1;
              bus.s1   <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SEL_V: begin
            if (dwell_done) begin
              stage[1] <= bus.m;
              cnt      <= '0;
              state    <= SEL_W;
              bus.s0   <= 1'b0;
              bus.s1   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SEL_W: begin
            if (dwell_done) begin
              bus.sample       <= {bus.m, stage};
              bus.sample_valid <= 1'b1;
              cnt              <= '0;
              bus.s0           <= 1'b0;
              bus.s1           <= 1'b0;
              if (bus.cont) begin
                state <= SEL_U;
              end else begin
                state    <= IDLE;
                bus.busy <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            cnt      <= '0;
            bus.s0   <= 1'b0;
            bus.s1   <= 1'b0;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (DWELL=4 and DWELL=1) share control and source inputs.
// A cycle-position model predicts every output; directed scenarios pin literal values.
// Each instance's m comes from a combinational mux of u/v/w driven by its own selects.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic abort = 1'b0;
  logic u = 1'b0;
  logic v = 1'b0;
  logic w = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_scan_sequencer_if i4 ();
  mux_scan_sequencer_if i1 ();

  assign i4.start = start;
  assign i4.cont  = cont;
  assign i4.abort = abort;
  assign i4.m     = i4.s1 ? w : (i4.s0 ? v : u);
  assign i1.start = start;
  assign i1.cont  = cont;
  assign i1.abort = abort;
  assign i1.m     = i1.s1 ? w : (i1.s0 ? v : u);

  mux_scan_sequencer #(.DWELL(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  mux_scan_sequencer #(.DWELL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  // Model: per instance, an active flag and the cycle position t within the 3*D-cycle scan.
  int         dw[2] = '{4, 1};
  bit         mact[2] = '{0, 0};
  int         mt[2] = '{0, 0};
  logic [2:0] mstg[2] = '{3'b000, 3'b000};
  logic [2:0] msamp[2] = '{3'b000, 3'b000};
  bit         msv[2] = '{0, 0};

  function automatic logic src_bit(int s);
    return (s == 0) ? u : ((s == 1) ? v : w);
  endfunction

  function automatic logic [1:0] exp_sel(int k);
    int s;
    if (!mact[k]) return 2'b00;
    s = mt[k] / dw[k];
    return (s == 0) ? 2'b00 : ((s == 1) ? 2'b01 : 2'b10);
  endfunction

  // Reference model update on each clock edge and on async reset.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mact[k]  <= 1'b0;
        mt[k]    <= 0;
        mstg[k]  <= 3'b000;
        msamp[k] <= 3'b000;
        msv[k]   <= 1'b0;
      end else begin
        msv[k] <= 1'b0;
        if (abort) begin
          mact[k] <= 1'b0;
          mt[k]   <= 0;
          mstg[k] <= 3'b000;
        end else if (!mact[k]) begin
          if (start) begin
            mact[k] <= 1'b1;
            mt[k]   <= 0;
          end
        end else if (mt[k] == 3 * dw[k] - 1) begin
          msamp[k] <= {src_bit(2), mstg[k][1], mstg[k][0]};
          msv[k]   <= 1'b1;
          mact[k]  <= cont;
          mt[k]    <= 0;
          mstg[k]  <= 3'b000;
        end else begin
          if (mt[k] % dw[k] == dw[k] - 1) mstg[k][mt[k] / dw[k]] <= src_bit(mt[k] / dw[k]);
          mt[k] <= mt[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("sel4",    {2'b00, i4.s1, i4.s0}, {2'b00, exp_sel(0)});
    chk("busy4",   {3'b000, i4.busy}, {3'b000, mact[0]});
    chk("sample4", {1'b0, i4.sample}, {1'b0, msamp[0]});
    chk("svld4",   {3'b000, i4.sample_valid}, {3'b000, msv[0]});
    chk("sel11_4", {3'b000, (i4.s1 & i4.s0)}, 4'h0);
    chk("sel1",    {2'b00, i1.s1, i1.s0}, {2'b00, exp_sel(1)});
    chk("busy1",   {3'b000, i1.busy}, {3'b000, mact[1]});
    chk("sample1", {1'b0, i1.sample}, {1'b0, msamp[1]});
    chk("svld1",   {3'b000, i1.sample_valid}, {3'b000, msv[1]});
    chk("sel11_1", {3'b000, (i1.s1 & i1.s0)}, 4'h0);
  end

  // Start captured at the second edge of this task (E0); returns 2 time units after E0.
  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int pulses;
  int busy_low;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",    {2'b00, i4.s1, i4.s0}, 4'h0);
    chk("rst_busy",   {3'b000, i4.busy}, 4'h0);
    chk("rst_sample", {1'b0, i4.sample}, 4'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    cycles(2);

    // Single scan u=1 v=0 w=1
    u = 1'b1; v = 1'b0; w = 1'b1;
    pulse_start();
    chk("scan_sel_u", {2'b00, i4.s1, i4.s0}, 4'h0);
    chk("scan_busy",  {3'b000, i4.busy}, 4'h1);
    cycles(4);
    chk("scan_sel_v", {2'b00, i4.s1, i4.s0}, 4'h1);
    cycles(4);
    chk("scan_sel_w", {2'b00, i4.s1, i4.s0}, 4'h2);
    cycles(4);
    chk("scan_svld",   {3'b000, i4.sample_valid}, 4'h1);
    chk("scan_sample", {1'b0, i4.sample}, 4'h5);
    chk("scan_done",   {3'b000, i4.busy}, 4'h0);
    cycles(2);

    // Source isolation
    u = 1'b0; v = 1'b1; w = 1'b0;
    pulse_start();
    cycles(12);
    chk("iso_010", {1'b0, i4.sample}, 4'h2);
    u = 1'b1; v = 1'b1; w = 1'b0;
    pulse_start();
    cycles(12);
    chk("iso_011", {1'b0, i4.sample}, 4'h3);
    cycles(2);

    // Start while busy: re-asserted during cycles 5..6
    u = 1'b1; v = 1'b0; w = 1'b1;
    pulse_start();
    cycles(4);
    start = 1'b1;
    cycles(2);
    start = 1'b0;
    cycles(6);
    chk("rb_svld",   {3'b000, i4.sample_valid}, 4'h1);
    chk("rb_sample", {1'b0, i4.sample}, 4'h5);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pulses += int'(i4.sample_valid) - ((i == 0) ? 1 : 0);
      busy_low += 0;
    end
    chk("rb_extra_pulses", 4'(pulses), 4'h0);
    chk("rb_idle", {3'b000, i4.busy}, 4'h0);
    cycles(1);

    // Abort at cycle 9 with sources that would change the result
    u = 1'b0; v = 1'b0; w = 1'b0;
    pulse_start();
    cycles(8);
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    chk("ab_busy",   {3'b000, i4.busy}, 4'h0);
    chk("ab_sample", {1'b0, i4.sample}, 4'h5);
    chk("ab_svld",   {3'b000, i4.sample_valid}, 4'h0);
    chk("ab_sel",    {2'b00, i4.s1, i4.s0}, 4'h0);
    u = 1'b0; v = 1'b1; w = 1'b1;
    pulse_start();
    cycles(12);
    chk("ab_rescan", {1'b0, i4.sample}, 4'h6);
    chk("ab_rescan_vld", {3'b000, i4.sample_valid}, 4'h1);
    cycles(3);

    // Continuous mode, DWELL=1 instance, w toggled between its captures
    cont = 1'b1;
    u = 1'b1; v = 1'b0; w = 1'b0;
    pulse_start();
    pulses = 0;
    busy_low = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2;
      if (i % 3 == 2) w = ~w;
      @(negedge clk);
      pulses += int'(i1.sample_valid);
      if (!i1.busy) busy_low++;
    end
    chk("cont_pulses", 4'(pulses), 4'hA);
    chk("cont_busy_low", 4'(busy_low), 4'h0);
    @(posedge clk); #2 cont = 1'b0;
    cycles(4);
    chk("cont_end1", {3'b000, i1.busy}, 4'h0);
    cycles(14);
    chk("cont_end4", {3'b000, i4.busy}, 4'h0);

    // Async reset mid-scan
    u = 1'b1; v = 1'b1; w = 1'b1;
    pulse_start();
    cycles(5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sel",    {2'b00, i4.s1, i4.s0}, 4'h0);
    chk("arst_busy",   {3'b000, i4.busy}, 4'h0);
    chk("arst_sample", {1'b0, i4.sample}, 4'h0);
    chk("arst_svld",   {3'b000, i4.sample_valid}, 4'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    cycles(2);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      u     = 1'($urandom_range(0, 1));
      v     = 1'($urandom_range(0, 1));
      w     = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 3) == 0);
      cont  = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 40) == 0);
      cycles(1);
    end
    start = 1'b0; cont = 1'b0; abort = 1'b0;
    cycles(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
